mpi_link_arbiter: RTL and testbench
===================================

MPI_LINK_ARBITER -- requirements
Module: mpi_link_arbiter

Interface
REQ-001 SHALL have parameter NUM_CH, default 3: number of local requester channels sharing one MPI send slot.
REQ-002 SHALL have parameter CRED_MAX, default 8: initial and maximum credits per channel.
REQ-003 SHALL have parameter DATA_W, default 64: flit width.
REQ-004 clk_i  input  1  clock; all logic on its rising edge.
REQ-005 rstn_i  input  1  reset, asynchronous, active-low.
REQ-006 enable_i  input  1  arbitration enable; when low, no new grant is issued.
REQ-007 req_valid_i  input  NUM_CH  per-channel flit request.
REQ-008 req_data_i  input  NUM_CH x DATA_W  per-channel flit.
REQ-009 req_ready_o  output  NUM_CH  one-cycle pulse: flit of that channel consumed.
REQ-010 yummy_i  input  NUM_CH  per-channel credit return from remote rank, one credit per cycle high.
REQ-011 tx_valid_o  output  1  flit presented to the MPI send slot.
REQ-012 tx_data_o  output  DATA_W  flit being sent.
REQ-013 tx_chan_o  output  CH_W = clog2(NUM_CH)  channel id of tx_data_o.
REQ-014 tx_ack_i  input  1  send slot accepted the flit this cycle.
REQ-015 credit_o  output  NUM_CH x CNT_W = clog2(CRED_MAX+1)  current credit count per channel.
REQ-016 err_o  output  1  sticky credit-overflow flag.

Function
REQ-017 FSM states: IDLE, GRANT, SEND.
REQ-018 Channel is eligible when req_valid_i[c]=1 and credit[c]>0.
REQ-019 IDLE -> GRANT when enable_i=1 and at least one channel is eligible; otherwise stay in IDLE.
REQ-020 Winner is the first eligible channel at or after rr_ptr, searching upward and wrapping from NUM_CH-1 to 0.
REQ-021 GRANT (1 cycle): latch winner data and id, pulse req_ready_o[winner], decrement credit[winner], go to SEND.
REQ-022 SEND: hold tx_valid_o=1 with stable tx_data_o/tx_chan_o until the cycle tx_ack_i=1; go to IDLE the next cycle.
REQ-023 On leaving SEND, rr_ptr = winner+1 modulo NUM_CH.
REQ-024 Latency: req_valid_i sampled in IDLE -> tx_valid_o asserted 2 cycles later; minimum 3 cycles per flit.
REQ-025 tx_valid_o=0 outside SEND; tx_ack_i outside SEND is ignored.
REQ-026 yummy_i[c]=1 increments credit[c] in any state.
REQ-027 Decrement and yummy on the same channel in the same cycle leave credit unchanged.
REQ-028 Increment at credit=CRED_MAX saturates at CRED_MAX and sets err_o; err_o clears only on reset.
REQ-029 Credit=0 on a channel with req_valid_i=1 blocks only that channel; the others still win.
REQ-030 enable_i dropping during GRANT/SEND does not abort the transfer in flight.
REQ-031 req_valid_i deasserting after GRANT does not affect the latched flit.

Reset
REQ-032 On rstn_i low, immediately: state=IDLE, rr_ptr=0, credit[all]=CRED_MAX, err_o=0, tx_valid_o=0, tx_data_o=0, tx_chan_o=0, req_ready_o=0.
REQ-033 Reset mid-SEND drops the flit; the credit already consumed is restored to CRED_MAX by reset.

Structure
REQ-034 metro_mpi_pkg SHALL hold the arb_state_t enum (IDLE/GRANT/SEND) and the default NUM_CH/CRED_MAX/DATA_W constants.
REQ-035 Per-channel credit counter SHALL be a sub-module, mpi_credit_counter (inc, dec, count, overflow), instantiated NUM_CH times.

Verification
REQ-036 Reset, then ch0 valid with data 0xA5 -> req_ready_o[0] pulses at GRANT; tx_data_o=0xA5, tx_chan_o=0 at SEND; credit_o[0]=7.
REQ-037 All 3 channels valid continuously, tx_ack_i tied high -> grants in order 0,1,2,0,...; one flit every 3 cycles.
REQ-038 Ch1 sends 8 flits with no yummy -> credit_o[1]=0, ch1 blocked, ch2 still granted; one yummy_i[1] -> ch1 granted again.
REQ-039 Yummy_i[0] while credit_o[0]=8 -> credit stays 8, err_o=1 and stays 1.
REQ-040 Yummy_i[2] in the same cycle as ch2's GRANT -> credit_o[2] unchanged.
REQ-041 Hold tx_ack_i low for 5 cycles in SEND, then assert rstn_i low -> tx_valid_o=0 immediately, credits=8, state IDLE.

Source files
------------

// File: rtl/metro_mpi_pkg.sv
// rtl/metro_mpi_pkg.sv - shared types and default sizing for the MPI link arbiter
package metro_mpi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        SEND  = 2'd2
    } arb_state_t;

    localparam int DEF_NUM_CH   = 3;
    localparam int DEF_CRED_MAX = 8;
    localparam int DEF_DATA_W   = 64;

endpackage

// File: rtl/mpi_credit_counter.sv
// rtl/mpi_credit_counter.sv - saturating per-channel credit counter with sticky overflow
module mpi_credit_counter
    import metro_mpi_pkg::*;
#(
    parameter int  CRED_MAX = DEF_CRED_MAX,
    localparam int CNT_W    = $clog2(CRED_MAX + 1)
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             overflow
);

    // Credit return and consumption in the same cycle cancel; a return at full
    // credit is dropped and latched as an overflow until the next reset.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            count    <= CNT_W'(CRED_MAX);
            overflow <= 1'b0;
        end else begin
            case ({inc, dec})
                2'b10: begin
                    if (count == CNT_W'(CRED_MAX)) begin
                        overflow <= 1'b1;
                    end else begin
                        count <= count + CNT_W'(1);
                    end
                end
                2'b01: begin
                    if (count != '0) begin
                        count <= count - CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/mpi_link_arbiter.sv
// rtl/mpi_link_arbiter.sv - credit-aware round-robin arbiter feeding one MPI send slot
module mpi_link_arbiter
    import metro_mpi_pkg::*;
#(
    parameter int  NUM_CH   = DEF_NUM_CH,
    parameter int  CRED_MAX = DEF_CRED_MAX,
    parameter int  DATA_W   = DEF_DATA_W,
    localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int CNT_W    = $clog2(CRED_MAX + 1)
) (
    input  logic                           clk_i,
    input  logic                           rstn_i,
    input  logic                           enable_i,
    input  logic [NUM_CH-1:0]              req_valid_i,
    input  logic [NUM_CH-1:0][DATA_W-1:0]  req_data_i,
    output logic [NUM_CH-1:0]              req_ready_o,
    input  logic [NUM_CH-1:0]              yummy_i,
    output logic                           tx_valid_o,
    output logic [DATA_W-1:0]              tx_data_o,
    output logic [CH_W-1:0]                tx_chan_o,
    input  logic                           tx_ack_i,
    output logic [NUM_CH-1:0][CNT_W-1:0]   credit_o,
    output logic                           err_o
);

    arb_state_t        state;
    arb_state_t        state_nxt;
    logic [CH_W-1:0]   rr_ptr;
    logic [CH_W-1:0]   win_ch;
    logic [CH_W-1:0]   pick;
    logic [CH_W-1:0]   rr_after;
    logic              found;
    logic [NUM_CH-1:0] eligible;
    logic [NUM_CH-1:0] ovf;
    int                idx;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_cred
        mpi_credit_counter #(
            .CRED_MAX (CRED_MAX)
        ) u_cnt (
            .clk_i    (clk_i),
            .rstn_i   (rstn_i),
            .inc      (yummy_i[c]),
            .dec      (req_ready_o[c]),
            .count    (credit_o[c]),
            .overflow (ovf[c])
        );
    end

    assign err_o    = |ovf;
    assign rr_after = (win_ch == CH_W'(NUM_CH - 1)) ? '0 : win_ch + CH_W'(1);

    // A channel may compete only while it has a flit and at least one credit.
    always_comb begin
        eligible = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            eligible[c] = req_valid_i[c] && (credit_o[c] != '0);
        end
    end

    // First eligible channel at or after rr_ptr, wrapping past the top channel.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= NUM_CH) begin
                idx = idx - NUM_CH;
            end
            if (!found && eligible[CH_W'(idx)]) begin
                found = 1'b1;
                pick  = CH_W'(idx);
            end
        end
    end

    // Next-state and handshake outputs; a transfer in flight ignores enable_i.
    always_comb begin
        state_nxt   = state;
        req_ready_o = '0;
        tx_valid_o  = 1'b0;
        case (state)
            IDLE: begin
                if (enable_i && found) begin
                    state_nxt = GRANT;
                end
            end
            GRANT: begin
                req_ready_o[win_ch] = 1'b1;
                state_nxt           = SEND;
            end
            SEND: begin
                tx_valid_o = 1'b1;
                if (tx_ack_i) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Winner capture, flit latch during GRANT and pointer advance after the send.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            rr_ptr    <= '0;
            win_ch    <= '0;
            tx_data_o <= '0;
            tx_chan_o <= '0;
        end else begin
            if (state == IDLE && enable_i && found) begin
                win_ch <= pick;
            end
            if (state == GRANT) begin
                tx_data_o <= req_data_i[win_ch];
                tx_chan_o <= win_ch;
            end
            if (state == SEND && tx_ack_i) begin
                rr_ptr <= rr_after;
            end
        end
    end

endmodule

// File: tb/tb_mpi_link_arbiter.sv
// tb/tb_mpi_link_arbiter.sv - scoreboard bench for mpi_link_arbiter
module tb_mpi_link_arbiter;

    localparam int N  = 3;
    localparam int CM = 8;
    localparam int DW = 64;

    typedef struct {
        int            ch;
        logic [DW-1:0] data;
    } tx_t;

    logic                  clk = 1'b0;
    logic                  rstn = 1'b0;
    logic                  enable = 1'b0;
    logic [N-1:0]          req_valid = '0;
    logic [N-1:0][DW-1:0]  req_data = '0;
    logic [N-1:0]          req_ready;
    logic [N-1:0]          yummy = '0;
    logic                  tx_valid;
    logic [DW-1:0]         tx_data;
    logic [1:0]            tx_chan;
    logic                  tx_ack = 1'b0;
    logic [N-1:0][3:0]     credit;
    logic                  err;

    int vectors = 0;
    int miscompares = 0;

    // reference model state
    int  m_credit [N];
    bit  m_err;
    int  m_rr;
    bit  in_flight;
    bit  granting;
    int  cur_ch;

    // expectations published for the monitor
    logic [N-1:0]      exp_ready;
    logic              exp_txv;
    logic [N-1:0][3:0] exp_credit;
    logic              exp_err;
    int                exp_gnt [$];
    tx_t               exp_tx [$];

    // stimulus knobs and per-channel flit queues
    logic [DW-1:0] cq [N][$];
    int            gen_pct = 0;
    int            y_pct = 0;
    int            ack_pct = 100;
    int            en_pct = 100;
    logic [N-1:0]  ymask_once = '0;
    logic [N-1:0]  y_on_grant = '0;

    mpi_link_arbiter #(.NUM_CH(N), .CRED_MAX(CM), .DATA_W(DW)) dut (
        .clk_i       (clk),
        .rstn_i      (rstn),
        .enable_i    (enable),
        .req_valid_i (req_valid),
        .req_data_i  (req_data),
        .req_ready_o (req_ready),
        .yummy_i     (yummy),
        .tx_valid_o  (tx_valid),
        .tx_data_o   (tx_data),
        .tx_chan_o   (tx_chan),
        .tx_ack_i    (tx_ack),
        .credit_o    (credit),
        .err_o       (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name, input logic [63:0] act);
        vectors++;
        miscompares++;
        $display("FAIL %s: got %0h with nothing expected at %0t", name, act, $time);
    endtask

    task automatic publish_credits();
        for (int c = 0; c < N; c++) exp_credit[c] = 4'(m_credit[c]);
        exp_err = m_err;
    endtask

    task automatic m_reset();
        for (int c = 0; c < N; c++) m_credit[c] = CM;
        m_err = 0; m_rr = 0; in_flight = 0; granting = 0; cur_ch = 0;
        exp_gnt.delete();
        exp_tx.delete();
        exp_ready = '0;
        exp_txv = 1'b0;
        publish_credits();
    endtask

    // One clock of stimulus plus the reference model's view of that clock.
    task automatic step();
        logic [N-1:0]         v;
        logic [N-1:0]         y;
        logic [N-1:0]         rdy;
        logic [N-1:0][DW-1:0] d;
        logic                 ack;
        logic                 en;
        bit                   got;

        rdy = granting ? N'(1 << cur_ch) : '0;
        exp_ready = rdy;
        exp_txv = in_flight && !granting;
        publish_credits();

        for (int c = 0; c < N; c++) begin
            if (cq[c].size() == 0 && int'($urandom_range(99)) < gen_pct)
                cq[c].push_back({$urandom(), $urandom()});
            v[c] = cq[c].size() > 0;
            d[c] = v[c] ? cq[c][0] : '0;
            y[c] = (int'($urandom_range(99)) < y_pct) || ymask_once[c] || (y_on_grant[c] && rdy[c]);
        end
        ymask_once = '0;
        ack = int'($urandom_range(99)) < ack_pct;
        en  = int'($urandom_range(99)) < en_pct;

        req_valid = v; req_data = d; yummy = y; tx_ack = ack; enable = en;

        if (granting) begin
            exp_tx.push_back('{ch: cur_ch, data: d[cur_ch]});
            void'(cq[cur_ch].pop_front());
            granting = 0;
        end else if (in_flight) begin
            if (ack) begin
                in_flight = 0;
                m_rr = (cur_ch + 1) % N;
            end
        end else if (en) begin
            got = 0;
            for (int k = 0; k < N; k++) begin
                int c;
                c = (m_rr + k) % N;
                if (!got && v[c] && m_credit[c] > 0) begin
                    got = 1; cur_ch = c; in_flight = 1; granting = 1;
                    exp_gnt.push_back(c);
                end
            end
        end

        for (int c = 0; c < N; c++) begin
            if (y[c] && !rdy[c]) begin
                if (m_credit[c] == CM) m_err = 1;
                else m_credit[c] = m_credit[c] + 1;
            end else if (!y[c] && rdy[c]) begin
                m_credit[c] = m_credit[c] - 1;
            end
        end

        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Monitor: per-cycle outputs against the model, flits against the scoreboard.
    always @(negedge clk) begin
        if (rstn) begin
            check("tx_valid", 64'(tx_valid), 64'(exp_txv));
            check("req_ready", 64'(req_ready), 64'(exp_ready));
            check("credit", 64'(credit), 64'(exp_credit));
            check("err", 64'(err), 64'(exp_err));
            if (req_ready != '0) begin
                if (exp_gnt.size() == 0) fail("grant_unexpected", 64'(req_ready));
                else check("grant_chan", 64'(req_ready), 64'(1) << exp_gnt.pop_front());
            end
            if (tx_valid) begin
                if (exp_tx.size() == 0) begin
                    fail("tx_unexpected", tx_data);
                end else begin
                    check("tx_data", tx_data, exp_tx[0].data);
                    check("tx_chan", 64'(tx_chan), 64'(exp_tx[0].ch));
                    if (tx_ack) void'(exp_tx.pop_front());
                end
            end
        end
    end

    task automatic reset_checks(input string tag);
        check({tag, "_tx_valid"}, 64'(tx_valid), 64'(0));
        check({tag, "_tx_data"}, tx_data, 64'(0));
        check({tag, "_tx_chan"}, 64'(tx_chan), 64'(0));
        check({tag, "_req_ready"}, 64'(req_ready), 64'(0));
        check({tag, "_credit"}, 64'(credit), 64'h888);
        check({tag, "_err"}, 64'(err), 64'(0));
    endtask

    initial begin
        int waited;
        m_reset();
        @(negedge clk);
        reset_checks("reset");
        @(posedge clk);
        #1;
        rstn = 1'b1;

        // single flit 0xA5 on channel 0
        cq[0].push_back(64'hA5);
        run(6);
        check("a5_credit0", 64'(credit[0]), 64'd7);
        ymask_once = 3'b001;
        run(2);

        // all channels busy, ack always high: strict 0,1,2 rotation, one flit per 3 cycles
        for (int c = 0; c < N; c++)
            for (int k = 0; k < 4; k++) cq[c].push_back({$urandom(), $urandom()});
        run(40);
        for (int i = 0; i < 4; i++) begin
            ymask_once = 3'b111;
            step();
        end

        // channel 1 exhausts its credits, channel 2 still served, one credit revives ch1
        for (int k = 0; k < 9; k++) cq[1].push_back({$urandom(), $urandom()});
        run(30);
        check("ch1_drained", 64'(credit[1]), 64'd0);
        for (int k = 0; k < 2; k++) cq[2].push_back({$urandom(), $urandom()});
        run(10);
        check("ch1_blocked", 64'(credit[1]), 64'd0);
        check("ch2_served", 64'(credit[2]), 64'd6);
        ymask_once = 3'b010;
        run(8);
        check("ch1_revived", 64'(credit[1]), 64'd0);
        for (int i = 0; i < 8; i++) begin
            ymask_once = (i < 2) ? 3'b110 : 3'b010;
            step();
        end

        // credit return on channel 2 in its own GRANT cycle
        cq[2].push_back({$urandom(), $urandom()});
        y_on_grant = 3'b100;
        run(6);
        y_on_grant = '0;
        check("ch2_cancel", 64'(credit[2]), 64'd8);
        check("no_err_yet", 64'(err), 64'd0);

        // return at full credit: saturate and latch the error
        ymask_once = 3'b001;
        step();
        check("ovf_err", 64'(err), 64'd1);
        check("ovf_credit0", 64'(credit[0]), 64'd8);
        run(5);
        check("ovf_sticky", 64'(err), 64'd1);

        // randomized traffic, credits, acks and enable
        for (int s = 0; s < 6; s++) begin
            gen_pct = int'($urandom_range(90, 10));
            y_pct   = int'($urandom_range(30, 0));
            ack_pct = int'($urandom_range(100, 20));
            en_pct  = int'($urandom_range(100, 50));
            run(250);
        end

        // stall in SEND with ack low, then reset mid-transfer
        gen_pct = 0; y_pct = 20; ack_pct = 0; en_pct = 100;
        if (cq[0].size() == 0) cq[0].push_back(64'h5A5A);
        waited = 0;
        while (!(in_flight && !granting) && waited < 40) begin
            step();
            waited++;
        end
        if (!(in_flight && !granting)) fail("send_not_reached", 64'(waited));
        y_pct = 0;
        run(5);
        #2;
        rstn = 1'b0;
        #1;
        m_reset();
        reset_checks("midsend");
        @(posedge clk);
        @(posedge clk);
        #1;
        rstn = 1'b1;

        // drain and confirm nothing outstanding
        ack_pct = 100;
        run(40);
        check("gnt_queue_empty", 64'(exp_gnt.size()), 64'd0);
        check("tx_queue_empty", 64'(exp_tx.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
